// File: rtl/music_seq_ctrl_pkg.sv
// Shared types and constants for the song RAM sequencer.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACK,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } state_e;

  localparam logic [7:0] ACK_BYTE  = 8'h42;
  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_END  = 5'h1F;

endpackage

// File: rtl/music_seq_ctrl_if.sv
// Bundle of UART, keypad, song RAM and piano signals around the sequencer.
interface music_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int NOTE_W = 5
) ();

  logic              rx_data_valid;
  logic [7:0]        rx_data_out;
  logic              tx_busy;
  logic              key_load;
  logic              key_play;
  logic              key_stop;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [NOTE_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [NOTE_W-1:0] ram_rdata;
  logic [NOTE_W-1:0] note_out;
  logic              tx_data_valid;
  logic [7:0]        tx_data_in;
  logic              song_loaded;
  logic              playing;

  // The sequencer itself.
  modport master (
    input  rx_data_valid, rx_data_out, tx_busy, key_load, key_play, key_stop, ram_rdata,
    output ram_we, ram_waddr, ram_wdata, ram_raddr, note_out,
           tx_data_valid, tx_data_in, song_loaded, playing
  );

  // UART, keypad, RAM and piano surrounding it.
  modport slave (
    output rx_data_valid, rx_data_out, tx_busy, key_load, key_play, key_stop, ram_rdata,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr, note_out,
           tx_data_valid, tx_data_in, song_loaded, playing
  );

endinterface

// File: rtl/music_seq_ctrl_beat_timer.sv
// Loadable down-counter that times one note; expired is high while the count is zero.
module beat_timer #(
  parameter int BEAT_CYC = 1_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(BEAT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(BEAT_CYC - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/music_seq_ctrl.sv
// Song RAM owner: loads a song from UART, acknowledges it, then plays it one note per beat.
// Optional MUSIC_LOOP_PLAY_EN: restart from index 0 at end of song instead of returning to idle.
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int SIZE_MUSIC_MAX = 83,
  parameter int ADDR_W         = 8,
  parameter int NOTE_W         = 5,
  parameter int BEAT_CYC       = 1_500_000
) (
  input  logic             clk,
  input  logic             rst,
  music_seq_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE_MUSIC_MAX - 1);
  localparam logic [NOTE_W-1:0] N_REST   = NOTE_W'(NOTE_REST);
  localparam logic [NOTE_W-1:0] N_END    = NOTE_W'(NOTE_END);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] pidx_q, pidx_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [NOTE_W-1:0] wdata_q, wdata_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              end_q, end_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              loaded_q, loaded_d;
  logic              tmr_load, tmr_en, tmr_expired;

  beat_timer #(.BEAT_CYC(BEAT_CYC)) u_beat_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pidx_d     = pidx_q;
    ram_we_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    note_d     = note_q;
    end_d      = end_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    loaded_d   = loaded_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.key_load) begin
          state_d  = ST_LOAD;
          wcnt_d   = '0;
          loaded_d = 1'b0;
        end else if (bus.key_play && loaded_q) begin
          state_d = ST_FETCH;
          pidx_d  = '0;
        end
      end

      ST_LOAD: begin
        if (bus.key_stop) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b0;
        end else if (bus.rx_data_valid) begin
          ram_we_d = 1'b1;
          waddr_d  = wcnt_q;
          wdata_d  = bus.rx_data_out[NOTE_W-1:0];
          // The counter parks on the last index instead of wrapping.
          if (wcnt_q == LAST_IDX) begin
            state_d = ST_ACK;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_ACK: begin
        if (!bus.tx_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          loaded_d   = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        if (bus.key_stop) begin
          state_d = ST_IDLE;
          note_d  = N_REST;
        end else if (bus.key_load) begin
          state_d  = ST_LOAD;
          wcnt_d   = '0;
          loaded_d = 1'b0;
          note_d   = N_REST;
        end else begin
          unique case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
              // The end marker is played as a rest, never sent to the piano.
              end_d    = (bus.ram_rdata == N_END);
              note_d   = (bus.ram_rdata == N_END) ? N_REST : bus.ram_rdata;
              tmr_load = 1'b1;
              state_d  = ST_HOLD;
            end
            default: begin
              tmr_en = 1'b1;
              if (tmr_expired) begin
                if ((pidx_q == LAST_IDX) || end_q) begin
`ifdef MUSIC_LOOP_PLAY_EN
                  pidx_d  = '0;
                  state_d = ST_FETCH;
`else
                  note_d  = N_REST;
                  state_d = ST_IDLE;
`endif
                end else begin
                  pidx_d  = pidx_q + 1'b1;
                  state_d = ST_FETCH;
                end
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      pidx_q     <= '0;
      ram_we_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      note_q     <= '0;
      end_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pidx_q     <= pidx_d;
      ram_we_q   <= ram_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      note_q     <= note_d;
      end_q      <= end_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      loaded_q   <= loaded_d;
    end
  end

  // The play index register doubles as the read address, stable through FETCH.
  assign bus.ram_raddr     = pidx_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_waddr     = waddr_q;
  assign bus.ram_wdata     = wdata_q;
  assign bus.note_out      = note_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign bus.tx_data_in    = tx_data_q;
  assign bus.song_loaded   = loaded_q;
  assign bus.playing       = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_HOLD);

endmodule
